// File: rtl/adder_selftest_if.sv
// Operand/result bus between the self-test engine and the adder under test.
// The engine drives A/B as master; the adder returns Sum/Cout as slave.
interface adder_selftest_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output A,
    output B,
    input  Sum,
    input  Cout
  );

  modport slave (
    input  A,
    input  B,
    output Sum,
    output Cout
  );
endinterface

// File: rtl/adder_selftest.sv
// Exhaustive self-test engine for a WIDTH-bit adder.
// Sweeps every {A,B} pair, counts matches and mismatches, and latches the first failing vector.
module adder_selftest #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  adder_selftest_if.master     dut,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     pass_cnt,
  output logic [2*WIDTH:0]     fail_cnt,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = IW + 1;
  localparam logic [3:0] WAIT_LD = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      wait_q, wait_d;
  logic [CW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CW-1:0]   fail_cnt_q, fail_cnt_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [WIDTH:0]  exp_sum;
  logic            match;

  assign dut.A = idx_q[IW-1:WIDTH];
  assign dut.B = idx_q[WIDTH-1:0];

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = done_q & (fail_cnt_q == '0);
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;

  // Reference sum and comparison against the adder's response.
  always_comb begin
    exp_sum = {1'b0, dut.A} + {1'b0, dut.B};
    match   = (exp_sum == {dut.Cout, dut.Sum});
  end

  // Sweep sequencing, scoring and first-failure capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    busy_d     = (state_q == DRIVE) ||
                 (state_q == WAIT)  ||
                 (state_q == CHECK);
    done_d     = (state_q == DONE);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d      = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        wait_d  = WAIT_LD;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      CHECK: begin
        if (match) begin
          pass_cnt_d = pass_cnt_q + CW'(1);
        end else begin
          fail_cnt_d = fail_cnt_q + CW'(1);
          if (fail_cnt_q == '0) begin
            fail_a_d = dut.A;
            fail_b_d = dut.B;
          end
        end
        if (&idx_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/adder_selftest.md
Name: adder_selftest

Overview:
- On-board self-test engine that drives the A/B inputs of a WIDTH-bit ripple adder and checks its Sum/Cout outputs.
- It is the stimulus/response end of the adder interface: it generates operands, waits for the adder to settle, and compares the result against a reference sum.
- It sweeps all 2^(2*WIDTH) operand pairs exhaustively and reports pass/fail counts and the first failing vector, for display on board LEDs and seven-segment displays.

Parameters:
- WIDTH, 4, operand width of the adder under test.
- SETTLE, 2, cycles to wait after driving a vector before sampling the result; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- A  output  WIDTH  operand A to the adder.
- B  output  WIDTH  operand B to the adder.
- Sum  input  WIDTH  sum returned from the adder.
- Cout  input  1  carry-out returned from the adder.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high once a sweep has completed; held until the next start or rst.
- pass  output  1  equals done AND (fail_cnt == 0).
- pass_cnt  output  2*WIDTH+1  number of vectors that matched.
- fail_cnt  output  2*WIDTH+1  number of vectors that mismatched.
- fail_a  output  WIDTH  A operand of the first mismatch.
- fail_b  output  WIDTH  B operand of the first mismatch.

Behaviour:
- Reset: rst is sampled on the clock edge, so it is synchronous.
  - State goes to IDLE.
  - A, B, pass_cnt, fail_cnt, fail_a and fail_b are cleared to 0.
  - busy, done and pass are cleared to 0.
  - rst has priority over every other input in every state; asserting it mid-sweep aborts the sweep with no partial done.
- Vector index: idx = {A, B}, 2*WIDTH bits wide, with B as the low bits. The sweep order is A=0,B=0..max, then A=1,B=0..max, and so on. The last vector is all-ones.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
  - IDLE: start=1 clears the counters and the fail capture, sets idx=0, and moves to DRIVE. busy=1 from the next cycle.
  - DRIVE (1 cycle): A/B hold the current idx. Loads the wait counter with SETTLE-1. Moves to WAIT.
  - WAIT (SETTLE cycles): decrements the wait counter. Moves to CHECK when it reaches 0.
  - CHECK (1 cycle): computes expected = A + B, zero-extended to WIDTH+1 bits, and compares it with {Cout, Sum}.
    - Match: pass_cnt increments.
    - Mismatch: fail_cnt increments. If fail_cnt was 0 before this increment, A/B are captured into fail_a/fail_b. Later mismatches do not overwrite the capture.
    - If idx is all-ones, move to DONE. Otherwise idx increments and the state returns to DRIVE.
  - DONE: busy=0, done=1; A/B hold the last vector. start=1 restarts the sweep exactly as from IDLE, with done dropping the next cycle.
- start is ignored while busy=1.
- Latency: each vector takes SETTLE+2 cycles.
  - If start is sampled at edge 0, done=1 first at edge 2^(2*WIDTH)*(SETTLE+2)+1.
  - With defaults this is edge 1025.
- On completion, pass_cnt + fail_cnt = 2^(2*WIDTH) (256 by default). The counters cannot overflow because their width is 2*WIDTH+1.
- idx wrap-around never occurs, because the terminal check happens before the increment.
- If a start pulse and the terminal CHECK coincide, the sweep goes to DONE and the start is ignored.

Test Plan:
- Correct behavioural adder, default parameters, 1-cycle start at cycle 0:
  - busy=1 at cycle 1 and done=1 at cycle 1025.
  - pass_cnt=256, fail_cnt=0, pass=1.
- Adder model with Cout stuck at 0:
  - fail_cnt=120, pass_cnt=136, pass=0.
  - fail_a=1, fail_b=15.
- Adder model with Sum[0] stuck at 0:
  - fail_cnt=128, pass=0.
  - fail_a=0, fail_b=1.
- rst asserted for 1 cycle in WAIT of vector 37:
  - Next cycle: A=B=0, busy=done=0, counters=0.
  - A later start runs a full clean sweep to pass_cnt=256.
- start pulsed at cycles 0 and 50 (mid-sweep), then again 5 cycles after done:
  - The second pulse has no effect and done is still at cycle 1025.
  - The third pulse clears done and the counters and reruns the sweep.
- SETTLE=5 with a correct adder:
  - Each vector takes 7 cycles and done=1 at cycle 1793.
  - pass_cnt=256.
